// File: rtl/pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer: owns the fetch PC, issues imem requests, squashes stale responses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_fetch_sequencer #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  trap_valid,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  pc_sel
);

  localparam logic [1:0] c_st_boot  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] c_align_mask = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] c_pc_step    = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  kill_q, kill_d;
  logic                  hold_q, hold_d;
  logic                  pc_sel_q, pc_sel_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_WIDTH-1:0] inst_data_q, inst_data_d;

  logic                  w_redir;
  logic [ADDR_WIDTH-1:0] w_target_raw;
  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_rsp;

  assign w_redir      = trap_valid | redirect_valid;
  assign w_target_raw = trap_valid ? TRAP_VECTOR : redirect_target;
  assign w_target     = w_target_raw & c_align_mask;
  assign w_pc_plus4   = fetch_pc_q + c_pc_step;

  // Once a request is presented unaccepted, hold_q keeps it up regardless of stall.
  assign w_req_valid  = (state_q == c_st_issue) && (!stall || hold_q);
  assign w_accept     = w_req_valid && imem_req_ready;
  assign w_rsp        = (state_q == c_st_wait) && imem_rsp_valid;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    kill_d        = kill_q;
    hold_d        = hold_q;
    pc_sel_d      = 1'b0;
    inst_valid_d  = w_rsp && !kill_q && !w_redir;
    inst_pc_d     = inst_pc_q;
    inst_data_d   = inst_data_q;

    if (inst_valid_d) begin
      inst_pc_d   = req_pc_q;
      inst_data_d = imem_rsp_data;
    end

    case (state_q)
      c_st_boot: begin
        state_d = c_st_issue;
        hold_d  = 1'b0;
        if (w_redir) begin
          fetch_pc_d   = w_target;
          pc_sel_d     = 1'b1;
          pend_valid_d = 1'b0;
        end
      end

      c_st_issue: begin
        hold_d = w_req_valid && !imem_req_ready;
        if (w_accept) begin
          state_d      = c_st_wait;
          req_pc_d     = fetch_pc_q;
          kill_d       = w_redir || pend_valid_q;
          pend_valid_d = 1'b0;
          if (w_redir) begin
            fetch_pc_d = w_target;
            pc_sel_d   = 1'b1;
          end else if (pend_valid_q) begin
            fetch_pc_d = pend_target_q;
            pc_sel_d   = 1'b1;
          end else begin
            fetch_pc_d = w_pc_plus4;
          end
        end else if (w_redir) begin
          // A presented request must keep its address until accepted, so defer the target.
          if (w_req_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = w_target;
          end else begin
            fetch_pc_d   = w_target;
            pc_sel_d     = 1'b1;
            pend_valid_d = 1'b0;
          end
        end
      end

      c_st_wait: begin
        hold_d = 1'b0;
        if (w_redir) begin
          kill_d       = 1'b1;
          fetch_pc_d   = w_target;
          pc_sel_d     = 1'b1;
          pend_valid_d = 1'b0;
        end
        if (imem_rsp_valid) begin
          state_d = c_st_issue;
          kill_d  = 1'b0;
        end
      end

      default: begin
        state_d = c_st_boot;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_st_boot;
      fetch_pc_q    <= RESET_VECTOR;
      req_pc_q      <= RESET_VECTOR;
      pend_target_q <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      kill_q        <= 1'b0;
      hold_q        <= 1'b0;
      pc_sel_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_pc_q     <= '0;
      inst_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      kill_q        <= kill_d;
      hold_q        <= hold_d;
      pc_sel_q      <= pc_sel_d;
      inst_valid_q  <= inst_valid_d;
      inst_pc_q     <= inst_pc_d;
      inst_data_q   <= inst_data_d;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_pc        = inst_pc_q;
  assign inst_data      = inst_data_q;
  assign pc_sel         = pc_sel_q;

endmodule

`default_nettype wire
